core_bus_arbiter: RTL and testbench
===================================

Name: core_bus_arbiter

Overview:
- Sits directly downstream of the pipelined core. Takes its instruction-bus request (fetch) and data-bus request (memory stage) and merges them onto the single cache/memory bus (cbus).
- Arbitrates between the two, latches the winning request, and holds it stable on cbus until the transaction completes.
- Returns addr_ok/data_ok and read data to the granted port only; the losing port sees wait (stall) until granted.

Parameters:
- ADDR_W, 64, address width of ibus/dbus/cbus
- DATA_W, 64, cbus and dbus data width; ibus data is fixed at 32

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- ireq_valid  in  1  fetch request pending; held until iresp_data_ok
- ireq_addr  in  ADDR_W  fetch address (4-byte aligned)
- iresp_addr_ok  out  1  fetch request accepted
- iresp_data_ok  out  1  fetch data valid
- iresp_data  out  32  instruction word
- dreq_valid  in  1  data request pending; held until dresp_data_ok
- dreq_addr  in  ADDR_W  data address
- dreq_size  in  3  log2 bytes (0..3)
- dreq_strobe  in  8  byte write enables; all-zero means read
- dreq_data  in  DATA_W  store data, already lane-aligned
- dresp_addr_ok  out  1  data request accepted
- dresp_data_ok  out  1  data access done
- dresp_data  out  DATA_W  load data (full 64-bit lane)
- creq_valid  out  1  cbus request valid
- creq_is_write  out  1  1 = store
- creq_size  out  3  access size
- creq_addr  out  ADDR_W  access address
- creq_strobe  out  8  byte enables (0 for reads)
- creq_data  out  DATA_W  write data
- cresp_ready  in  1  cbus beat handshake
- cresp_last  in  1  final beat of transaction
- cresp_data  in  DATA_W  read data

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Reset state is IDLE.
- On reset, all outputs are 0: creq_valid=0, all ok flags=0, data outputs=0.
- IDLE transitions:
  - If dreq_valid: latch dreq fields, go to BUSY_D.
  - Else if ireq_valid: latch ireq_addr with size=2, strobe=0, is_write=0, go to BUSY_I.
  - Else stay in IDLE.
- Latency: a request is accepted in cycle N (IDLE sampled). creq_valid and the latched fields appear from N+1, driven from registers.
- creq_* stay constant while in a BUSY state, even if ireq/dreq inputs change or drop.
- creq_is_write = (latched strobe != 0).
- Completion: in BUSY_x, the cycle with cresp_ready && cresp_last:
  - Assert the granted port's addr_ok and data_ok combinationally in that same cycle, together with its data.
  - Go to IDLE.
  - The other port's ok flags stay 0.
- cresp_ready without cresp_last is ignored; no multi-beat assembly is needed.
- iresp_data = addr[2] of the latched fetch address ? cresp_data[63:32] : cresp_data[31:0].
- dresp_data = cresp_data unchanged. Load extension is the core's job.
- Back-to-back requests:
  - After completion the FSM is in IDLE the next cycle and re-arbitrates. A held-high valid in that cycle is treated as a new request.
  - Minimum issue spacing is 2 cycles per transaction.
- Simultaneous ireq_valid and dreq_valid in IDLE: dbus wins. The memory stage is older, so this avoids pipeline deadlock.
- A request that arrives while BUSY waits; no ok is given to it.
- Asynchronous reset mid-transaction: immediately IDLE, creq_valid=0, latched request discarded. cbus tolerates the abort.
- ok flags never assert outside a BUSY state.

Optional Feature:
- Macro: CORE_BUS_ARB_RR_EN
- Defined:
  - A 1-bit last_grant register (reset 0 = ibus) tracks the previous grant.
  - On simultaneous requests in IDLE, grant goes to the port opposite last_grant.
  - last_grant updates at each acceptance.
  - Single requesters are granted immediately as before.
- Undefined: fixed dbus priority; no last_grant register exists.

Test Plan:
- Lone fetch: ireq_valid=1, addr=0x8000_0004. IDLE→BUSY_I; next cycle creq_valid=1, addr=0x8000_0004, size=2, strobe=0. cresp ready+last with data=0xAAAA_BBBB_1111_2222 → iresp_data_ok=1, iresp_data=0xAAAA_BBBB. Then IDLE.
- Store: dreq addr=0x8000_1000, size=3, strobe=0xFF, data=0x1234. creq_is_write=1, fields match. Completion pulses dresp_addr_ok and dresp_data_ok for exactly 1 cycle; iresp stays 0.
- Contention: ireq and dreq both valid in IDLE. dbus served first. ibus is granted in the IDLE cycle after dbus completes; iresp_data_ok occurs no earlier than 2 cycles after dresp_data_ok. With CORE_BUS_ARB_RR_EN, a second simultaneous pair is served ibus first.
- Stability: in BUSY_D, change dreq_addr to 0xDEAD and drop dreq_valid. creq_addr stays latched; hold cresp_ready=1, cresp_last=0 for 3 cycles → no ok flag, state unchanged.
- Reset mid-op: assert reset while BUSY_I, asynchronously between clock edges. creq_valid=0 and iresp_data_ok=0 immediately. After release, state is IDLE and a new request is accepted normally.

Source files
------------

// File: rtl/core_bus_arbiter.sv
// Merges fetch (ibus) and memory-stage (dbus) requests onto one cbus; dbus wins ties unless CORE_BUS_ARB_RR_EN selects round-robin.
// Grant is registered (creq from cycle after acceptance); the loser stalls, and ok flags are combinational on the cresp last beat.
module core_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ireq_valid,
  input  logic [ADDR_W-1:0] i_ireq_addr,
  output logic              o_iresp_addr_ok,
  output logic              o_iresp_data_ok,
  output logic [31:0]       o_iresp_data,
  input  logic              i_dreq_valid,
  input  logic [ADDR_W-1:0] i_dreq_addr,
  input  logic [2:0]        i_dreq_size,
  input  logic [7:0]        i_dreq_strobe,
  input  logic [DATA_W-1:0] i_dreq_data,
  output logic              o_dresp_addr_ok,
  output logic              o_dresp_data_ok,
  output logic [DATA_W-1:0] o_dresp_data,
  output logic              o_creq_valid,
  output logic              o_creq_is_write,
  output logic [2:0]        o_creq_size,
  output logic [ADDR_W-1:0] o_creq_addr,
  output logic [7:0]        o_creq_strobe,
  output logic [DATA_W-1:0] o_creq_data,
  input  logic              i_cresp_ready,
  input  logic              i_cresp_last,
  input  logic [DATA_W-1:0] i_cresp_data
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            r_state;
  logic              r_creq_valid;
  logic              r_is_write;
  logic [2:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_strobe;
  logic [DATA_W-1:0] r_data;

  logic w_grant_d;
  logic w_grant_i;
  logic w_done;
  logic w_i_done;
  logic w_d_done;

`ifdef CORE_BUS_ARB_RR_EN
  // 0 = ibus was granted last, 1 = dbus; ties go to the other port
  logic r_last_grant;

  assign w_grant_d = i_dreq_valid && (!i_ireq_valid || !r_last_grant);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_last_grant <= 1'b0;
    end else if (r_state == IDLE && (i_dreq_valid || i_ireq_valid)) begin
      r_last_grant <= w_grant_d;
    end
  end
`else
  assign w_grant_d = i_dreq_valid;
`endif

  assign w_grant_i = i_ireq_valid && !w_grant_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_creq_valid <= 1'b0;
      r_is_write   <= 1'b0;
      r_size       <= '0;
      r_addr       <= '0;
      r_strobe     <= '0;
      r_data       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state      <= BUSY_D;
            r_creq_valid <= 1'b1;
            r_is_write   <= |i_dreq_strobe;
            r_size       <= i_dreq_size;
            r_addr       <= i_dreq_addr;
            r_strobe     <= i_dreq_strobe;
            r_data       <= i_dreq_data;
          end else if (w_grant_i) begin
            r_state      <= BUSY_I;
            r_creq_valid <= 1'b1;
            r_is_write   <= 1'b0;
            r_size       <= 3'd2;
            r_addr       <= i_ireq_addr;
            r_strobe     <= '0;
            r_data       <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // Fields stay latched after completion; only valid drops
          if (i_cresp_ready && i_cresp_last) begin
            r_state      <= IDLE;
            r_creq_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_creq_valid <= 1'b0;
        end
      endcase
    end
  end

  assign w_done   = r_creq_valid && i_cresp_ready && i_cresp_last;
  assign w_i_done = w_done && (r_state == BUSY_I);
  assign w_d_done = w_done && (r_state == BUSY_D);

  assign o_creq_valid    = r_creq_valid;
  assign o_creq_is_write = r_is_write;
  assign o_creq_size     = r_size;
  assign o_creq_addr     = r_addr;
  assign o_creq_strobe   = r_strobe;
  assign o_creq_data     = r_data;

  assign o_iresp_addr_ok = w_i_done;
  assign o_iresp_data_ok = w_i_done;
  // Fetch word comes from whichever 32-bit half of the 64-bit lane addr[2] picks
  assign o_iresp_data    = !w_i_done ? 32'h0 :
                           (r_addr[2] ? i_cresp_data[63:32] : i_cresp_data[31:0]);

  assign o_dresp_addr_ok = w_d_done;
  assign o_dresp_data_ok = w_d_done;
  assign o_dresp_data    = w_d_done ? i_cresp_data : '0;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Scoreboard bench for core_bus_arbiter: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_core_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic        creq_valid, creq_is_write;
  logic [2:0]  creq_size;
  logic [63:0] creq_addr;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ready, cresp_last;
  logic [63:0] cresp_data;

  always #5 clk = ~clk;

  core_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_ireq_valid(ireq_valid), .i_ireq_addr(ireq_addr),
    .o_iresp_addr_ok(iresp_addr_ok), .o_iresp_data_ok(iresp_data_ok), .o_iresp_data(iresp_data),
    .i_dreq_valid(dreq_valid), .i_dreq_addr(dreq_addr), .i_dreq_size(dreq_size),
    .i_dreq_strobe(dreq_strobe), .i_dreq_data(dreq_data),
    .o_dresp_addr_ok(dresp_addr_ok), .o_dresp_data_ok(dresp_data_ok), .o_dresp_data(dresp_data),
    .o_creq_valid(creq_valid), .o_creq_is_write(creq_is_write), .o_creq_size(creq_size),
    .o_creq_addr(creq_addr), .o_creq_strobe(creq_strobe), .o_creq_data(creq_data),
    .i_cresp_ready(cresp_ready), .i_cresp_last(cresp_last), .i_cresp_data(cresp_data)
  );

  typedef struct {
    logic        is_i;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   i_cyc   = 0;
  int   d_cyc   = 0;
  logic tb_last = 1'b0;  // model of last grant: 0 = ibus, 1 = dbus

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && (iresp_addr_ok || iresp_data_ok || dresp_addr_ok || dresp_data_ok)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ok", {60'h0, iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok}, 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_flags", {60'h0, iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok},
              mon_e.is_i ? 64'hC : 64'h3);
        check("resp_data", mon_e.is_i ? {32'h0, iresp_data} : dresp_data, mon_e.data);
        if (mon_e.is_i) i_cyc = cyc;
        else d_cyc = cyc;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_i, input logic [63:0] data);
    exp_t e;
    e.is_i = is_i;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic complete(input logic [63:0] d);
    cresp_ready = 1'b1;
    cresp_last  = 1'b1;
    cresp_data  = d;
    tick();
    cresp_ready = 1'b0;
    cresp_last  = 1'b0;
    cresp_data  = 64'h0;
  endtask

  task automatic set_dreq(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st, input logic [63:0] d);
    dreq_valid  = 1'b1;
    dreq_addr   = a;
    dreq_size   = sz;
    dreq_strobe = st;
    dreq_data   = d;
  endtask

  // Both ports request in the same IDLE cycle; all loads/fetches
  task automatic contend(input logic [63:0] ia, input logic [63:0] iword64, input logic [31:0] iexp,
                         input logic [63:0] da, input logic [63:0] ddat);
    logic d_first;
`ifdef CORE_BUS_ARB_RR_EN
    d_first = !tb_last;
`else
    d_first = 1'b1;
`endif
    ireq_valid = 1'b1;
    ireq_addr  = ia;
    set_dreq(da, 3'd3, 8'h00, 64'h0);
    if (d_first) begin push(1'b0, ddat); push(1'b1, {32'h0, iexp}); end
    else         begin push(1'b1, {32'h0, iexp}); push(1'b0, ddat); end
    tick();
    check("contend_first_addr", creq_addr, d_first ? da : ia);
    complete(d_first ? ddat : iword64);
    if (d_first) dreq_valid = 1'b0;
    else         ireq_valid = 1'b0;
    check("contend_gap_idle", creq_valid, 1'b0);
    tick();
    check("contend_second_addr", creq_addr, d_first ? ia : da);
    check("contend_second_size", creq_size, d_first ? 3'd2 : 3'd3);
    complete(d_first ? iword64 : ddat);
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    if (d_first) check("contend_spacing", (i_cyc - d_cyc) >= 2, 1'b1);
    else         check("contend_spacing", (d_cyc - i_cyc) >= 2, 1'b1);
    tb_last = d_first ? 1'b0 : 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ireq_valid = 1'b0; ireq_addr = 64'h0;
    dreq_valid = 1'b0; dreq_addr = 64'h0; dreq_size = 3'd0; dreq_strobe = 8'h0; dreq_data = 64'h0;
    cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = 64'h0;
    #12;
    check("rst_creq_valid", creq_valid, 1'b0);
    check("rst_creq_addr", creq_addr, 64'h0);
    check("rst_ok_flags", {iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok}, 4'h0);
    check("rst_data_out", dresp_data | {32'h0, iresp_data}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Lone fetch, upper half selected by addr[2]
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0004;
    push(1'b1, 64'h0000_0000_AAAA_BBBB);
    check("fetch_not_yet_valid", creq_valid, 1'b0);
    tick();
    check("fetch_creq_valid", creq_valid, 1'b1);
    check("fetch_creq_addr", creq_addr, 64'h8000_0004);
    check("fetch_creq_size", creq_size, 3'd2);
    check("fetch_creq_strobe", creq_strobe, 8'h00);
    check("fetch_creq_is_write", creq_is_write, 1'b0);
    complete(64'hAAAA_BBBB_1111_2222);
    ireq_valid = 1'b0;
    check("fetch_back_idle", creq_valid, 1'b0);
    tb_last = 1'b0;
    tick();

    // Store
    set_dreq(64'h8000_1000, 3'd3, 8'hFF, 64'h1234);
    push(1'b0, 64'h0);
    tick();
    check("store_is_write", creq_is_write, 1'b1);
    check("store_addr", creq_addr, 64'h8000_1000);
    check("store_size", creq_size, 3'd3);
    check("store_strobe", creq_strobe, 8'hFF);
    check("store_data", creq_data, 64'h1234);
    complete(64'h0);
    dreq_valid = 1'b0;
    tb_last = 1'b1;
    tick();

    contend(64'h8000_0008, 64'h9999_8888_1111_2222, 32'h1111_2222, 64'h8000_2000, 64'h0102_0304_0506_0708);
    tick();
    contend(64'h8000_000C, 64'h5555_6666_7777_8888, 32'h5555_6666, 64'h8000_2008, 64'hF0E0_D0C0_B0A0_9080);
    tick();

    // Stability: inputs change while BUSY_D, non-last beats ignored
    set_dreq(64'h8000_3000, 3'd2, 8'h00, 64'h0);
    push(1'b0, 64'hCAFE_F00D_1234_5678);
    tick();
    dreq_addr   = 64'hDEAD;
    dreq_valid  = 1'b0;
    cresp_ready = 1'b1;
    cresp_last  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stable_addr", creq_addr, 64'h8000_3000);
      check("stable_valid", creq_valid, 1'b1);
    end
    complete(64'hCAFE_F00D_1234_5678);
    tb_last = 1'b1;
    tick();

    // Asynchronous reset in BUSY_I with a completing beat present
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0010;
    tick();
    check("pre_reset_valid", creq_valid, 1'b1);
    cresp_ready = 1'b1;
    cresp_last  = 1'b1;
    cresp_data  = 64'h1;
    #2;
    rst = 1'b1;
    #1;
    check("reset_creq_valid", creq_valid, 1'b0);
    check("reset_iresp_ok", {iresp_addr_ok, iresp_data_ok}, 2'b00);
    cresp_ready = 1'b0;
    cresp_last  = 1'b0;
    cresp_data  = 64'h0;
    ireq_valid  = 1'b0;
    tb_last     = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("after_reset_idle", creq_valid, 1'b0);

    // Fresh fetch after reset, lower half
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0010;
    push(1'b1, 64'h0000_0000_3333_4444);
    tick();
    check("post_reset_addr", creq_addr, 64'h8000_0010);
    complete(64'h7777_6666_3333_4444);
    ireq_valid = 1'b0;
    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
